serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits; legal values are multiples of 4 and at least 8.
REQ-002 SHALL have port Clk, input, 1: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port Start, input, 1: level request to begin an operation.
REQ-005 SHALL have port Sub, input, 1: 0 computes A+B; 1 computes A-B.
REQ-006 SHALL have port A, input, WIDTH: operand A.
REQ-007 SHALL have port B, input, WIDTH: operand B.
REQ-008 SHALL have port Sum, output, WIDTH: registered result.
REQ-009 SHALL have port Cout, output, 1: registered carry out of the MSB (for Sub=1, 1 means no borrow).
REQ-010 SHALL have port Overflow, output, 1: registered two's-complement signed overflow.
REQ-011 SHALL have port Busy, output, 1: high while the nibble sequence is running.
REQ-012 SHALL have port Done, output, 1: high while the result is valid and the handshake is pending.

Function
REQ-013 SHALL compute the result with exactly one 4-bit ripple-carry adder slice, reused once per nibble, LSB nibble first; NIB = WIDTH/4 nibbles.
REQ-014 SHALL implement the states IDLE, ADD, DONE.
REQ-015 In IDLE with Start=1 at an edge, SHALL do all of the following, then enter ADD:
- latch A into an operand register;
- latch B XOR {WIDTH{Sub}} into an operand register;
- set the carry register to Sub;
- clear Sum, Cout and Overflow to 0;
- clear the nibble counter to 0.
REQ-016 In IDLE with Start=0, SHALL stay in IDLE and hold Sum, Cout and Overflow.
REQ-017 Each ADD edge SHALL:
- write slice sum bits [4i+3:4i] of Sum, where i is the nibble counter;
- load the slice carry-out into the carry register;
- increment i.
REQ-018 On the ADD edge with i=NIB-1, SHALL load Cout with the slice carry-out, load Overflow, and enter DONE.
REQ-019 Overflow SHALL equal (Aop[MSB]==Bop[MSB]) AND (Sum[MSB]!=Aop[MSB]), where Aop and Bop are the latched operands.
REQ-020 Latency SHALL be fixed: Start sampled at edge 0 -> Done=1 after edge NIB (4 for default WIDTH).
REQ-021 Start, Sub, A and B SHALL be ignored while in ADD; no restart and no operand change are allowed mid-sequence.
REQ-022 In DONE, Done SHALL be 1, and Sum, Cout and Overflow SHALL hold.
REQ-023 DONE SHALL exit to IDLE only on an edge with Start=0; Start held at 1 SHALL NOT retrigger.
REQ-024 Busy SHALL be 1 exactly in ADD; Done SHALL be 1 exactly in DONE; the two are never both 1.
REQ-025 Carry SHALL propagate between nibbles only through the carry register; there is no combinational path from Start, A or B to any output.
REQ-026 During ADD, Sum bits of not-yet-processed nibbles SHALL read 0.

Reset
REQ-027 Reset=1 at an edge SHALL force IDLE, clear Sum, Cout, Overflow, Busy, Done, the nibble counter, the carry register and the operand registers to 0, and take priority over Start in any state.
REQ-028 Reset asserted mid-ADD SHALL abandon the operation with no partial result retained; a new Start after reset release SHALL run normally.

Verification
REQ-029 Reset, then Start=1, A=0x1234, B=0x4321, Sub=0 -> Busy for 4 cycles, then Done=1, Sum=0x5555, Cout=0, Overflow=0.
REQ-030 A=0xFFFF, B=0x0001, Sub=0 -> Sum=0x0000, Cout=1, Overflow=0 (carry crosses all nibble boundaries).
REQ-031 A=0x7FFF, B=0x0001, Sub=0 -> Sum=0x8000, Cout=0, Overflow=1; A=0x8000, B=0x0005, Sub=1 -> Sum=0x7FFB, Cout=1, Overflow=1.
REQ-032 A=0x0005, B=0x0007, Sub=1 -> Sum=0xFFFE, Cout=0, Overflow=0.
REQ-033 Start held high through DONE -> Done stays 1 and no second sequence starts; then Start=0 -> IDLE next edge; toggling A and B during ADD -> result unchanged.
REQ-034 Reset pulsed on the third ADD cycle -> next cycle IDLE with Sum=0, Busy=0, Done=0; a following Start with 0x0F0F+0x00F1 -> Sum=0x1000.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial adder/subtractor. One 4-bit ripple-carry slice is reused
// once per nibble (LSB nibble first), with the inter-nibble carry held in
// a register. Operands are latched on Start, so the inputs are don't-care
// once the sequence is running.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned CntW = $clog2(NIB);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       slice_a, slice_b, slice_s;
  logic             slice_co;
  logic             last_nib;

  // Single 4-bit ripple-carry slice operating on the current nibble.
  always_comb begin
    logic c;
    slice_a = 4'(a_q >> {cnt_q, 2'b00});
    slice_b = 4'(b_q >> {cnt_q, 2'b00});
    slice_s = 4'b0000;
    c       = carry_q;
    for (int k = 0; k < 4; k++) begin
      slice_s[k] = slice_a[k] ^ slice_b[k] ^ c;
      c          = (slice_a[k] & slice_b[k]) | (c & (slice_a[k] ^ slice_b[k]));
    end
    slice_co = c;
  end

  assign last_nib = (cnt_q == CntW'(NIB - 1));

  // Next-state and datapath update for the IDLE/ADD/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          a_d     = A;
          b_d     = B ^ {WIDTH{Sub}};
          carry_d = Sub;  // +1 completes the two's-complement negate of B
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        // Unwritten nibbles are zero, so OR-ing the slice into place is a write.
        sum_d   = sum_q | (WIDTH'(slice_s) << {cnt_q, 2'b00});
        carry_d = slice_co;
        cnt_d   = cnt_q + CntW'(1);
        if (last_nib) begin
          cout_d  = slice_co;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
          state_d = StDone;
        end
      end
      StDone: begin
        if (!Start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Sum      = sum_q;
  assign Cout     = cout_q;
  assign Overflow = ovf_q;
  assign Busy     = (state_q == StAdd);
  assign Done     = (state_q == StDone);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: vector table plus random ops through a
// scoreboard queue, and hand sequences for hold-Start and mid-op reset.
module tb_serial_adder_ctrl;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic         Clk = 1'b0;
  logic         Reset, Start, Sub;
  logic [W-1:0] A, B;
  logic [W-1:0] Sum;
  logic         Cout, Overflow, Busy, Done;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Sub      (Sub),
    .A        (A),
    .B        (B),
    .Sum      (Sum),
    .Cout     (Cout),
    .Overflow (Overflow),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Whole-word reference for random operations.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0]   full;
    logic [W-1:0] bop;
    exp_t         e;
    bop    = b ^ {W{sub}};
    full   = {1'b0, a} + {1'b0, bop} + {{W{1'b0}}, sub};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bop[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  // One operation: push expectation, run, compare at Done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input exp_t e, input bit hold_start, input bit toggle);
    int   busy_cycles;
    exp_t got;
    @(negedge Clk);
    A = a; B = b; Sub = sub; Start = 1'b1;
    sb.push_back(e);
    @(negedge Clk);
    check("start_clears", {Sum, Cout, Overflow}, '0);
    if (!hold_start) Start = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 20 && !Done; k++) begin
      if (Busy) busy_cycles++;
      if (toggle) begin
        A = W'($urandom); B = W'($urandom); Sub = 1'($urandom);
      end
      @(negedge Clk);
    end
    check("done_seen", {31'd0, Done}, 32'd1);
    check("latency", busy_cycles, NIB);
    check("busy_in_done", {31'd0, Busy}, 32'd0);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      check("sum", {16'd0, Sum}, {16'd0, got.sum});
      check("cout", {31'd0, Cout}, {31'd0, got.cout});
      check("ovf", {31'd0, Overflow}, {31'd0, got.ovf});
    end else begin
      check("sb_nonempty", 32'd0, 32'd1);
    end
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb, held;
    logic         rs;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h0005, 1'b1, 16'h7FFB, 1'b1, 1'b1};
    vecs[4] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    Reset = 1'b1; Start = 1'b0; Sub = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge Clk);
    check("reset_outs", {Sum, Cout, Overflow, Busy, Done}, '0);
    Reset = 1'b0;

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      e = '{vecs[i].sum, vecs[i].cout, vecs[i].ovf};
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, e, 1'b0, 1'b0);
      @(negedge Clk);
      check("back_to_idle", {30'd0, Busy, Done}, 32'd0);
      check("idle_holds_sum", {16'd0, Sum}, {16'd0, vecs[i].sum});
    end

    // Random operations against the model.
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      run_op(ra, rb, rs, model(ra, rb, rs), 1'b0, 1'b0);
    end

    // Start held through DONE, inputs toggled during ADD.
    e = '{16'h5555, 1'b0, 1'b0};
    run_op(16'h1234, 16'h4321, 1'b0, e, 1'b1, 1'b1);
    held = Sum;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check("hold_done", {30'd0, Busy, Done}, 32'd1);
      check("hold_sum", {16'd0, Sum}, {16'd0, held});
    end
    Start = 1'b0;
    @(negedge Clk);
    check("release_idle", {30'd0, Busy, Done}, 32'd0);

    // Reset during the third ADD cycle.
    @(negedge Clk);
    A = 16'h1234; B = 16'h4321; Sub = 1'b0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("partial_sum", {16'd0, Sum}, 32'h0055);
    check("partial_busy", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_outs", {Sum, Cout, Overflow, Busy, Done}, '0);
    e = '{16'h1000, 1'b0, 1'b0};
    run_op(16'h0F0F, 16'h00F1, 1'b0, e, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
